// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues one word-aligned imem read at a time and
// holds the returned word in a single-entry register for decode. Redirects squash in-flight reads.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  assign redirect_target      = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    // A redirect always retargets the PC; only the state transition depends on where we are.
    if (i_redirect_valid) begin
      pc_d = redirect_target;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        if (i_imem_gnt) begin
          state_d = i_redirect_valid ? StDrain : StWait;
        end
      end
      StWait: begin
        if (i_redirect_valid) begin
          state_d = i_imem_rvalid ? StReq : StDrain;
        end else if (i_imem_rvalid) begin
          instr_d       = i_imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = StHold;
        end
      end
      StDrain: begin
        if (i_imem_rvalid) begin
          state_d = StReq;
        end
      end
      StHold: begin
        if (i_redirect_valid || i_instr_ready) begin
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
          state_d       = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign o_imem_req    = (state_q == StReq);
  assign o_imem_addr   = pc_q;
  assign o_instr_valid = instr_valid_q;
  assign o_instr       = instr_q;
  assign o_instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stream and a latency-randomized instruction memory.
module tb_instr_fetch;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  instr_fetch #(
    .RESET_PC (RstPc),
    .NOP_INSTR(Nop)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_gnt      (imem_gnt),
    .i_imem_rvalid   (imem_rvalid),
    .i_imem_rdata    (imem_rdata),
    .o_instr_valid   (instr_valid),
    .o_instr         (instr),
    .o_instr_pc      (instr_pc),
    .i_instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Memory model knobs and state
  int unsigned gnt_pct = 100;
  int unsigned spur_pct = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'hDEAD_BEEF;
  bit          mem_pend = 1'b0;
  int unsigned mem_cnt = 0;
  logic [31:0] mem_data = '0;

  // Fetch-stream model: what decode should see, independent of how the DUT sequences it
  bit          m_known = 1'b0;
  bit          m_idle  = 1'b0;
  bit          m_out   = 1'b0;  // a granted read belongs to the current stream or a squashed one
  bit          m_sq    = 1'b0;  // that outstanding read was squashed
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_next  = '0;  // PC of the next instruction the stream must deliver

  bit          seen_bad = 1'b0;
  logic [31:0] vq_pc[$];
  int          vq_cyc[$];
  logic [31:0] rq_addr[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit rd, input logic [31:0] tgt, input bit rdy);
    bit          exp_req, req_seen, g_drv, rv_drv, g_eff, rv_eff;
    logic [31:0] addr_seen, rdata_drv, tgt_al;
    exp_req   = !m_idle && !m_out && !m_valid;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    if (m_known) begin
      check_eq("req", 32'(imem_req), 32'(exp_req));
      check_eq("addr", imem_addr, m_next);
      check_eq("valid", 32'(instr_valid), 32'(m_valid));
      check_eq("instr", instr, m_instr);
      if (m_valid || m_idle) check_eq("instr_pc", instr_pc, m_pc);
    end
    if (instr_valid && instr == 32'hDEAD_BEEF) seen_bad = 1'b1;
    if (instr_valid) begin
      vq_pc.push_back(instr_pc);
      vq_cyc.push_back(cyc);
    end
    if (imem_req) rq_addr.push_back(imem_addr);

    g_drv = !mem_pend && ($urandom_range(99, 0) < gnt_pct);
    if (mem_pend && mem_cnt == 0) begin
      rv_drv    = 1'b1;
      rdata_drv = mem_data;
    end else begin
      rv_drv    = !mem_pend && ($urandom_range(99, 0) < spur_pct);
      rdata_drv = $urandom;
    end
    reset          = r;
    redirect_valid = rd;
    redirect_pc    = tgt;
    instr_ready    = rdy;
    imem_gnt       = g_drv;
    imem_rvalid    = rv_drv;
    imem_rdata     = rdata_drv;
    @(posedge clk);

    if (mem_pend && rv_drv) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (req_seen && g_drv) begin
      mem_pend = 1'b1;
      mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
      mem_data = ovr_en ? ovr_data : mem_fn(addr_seen);
    end

    tgt_al = tgt & 32'hFFFF_FFFC;
    if (r) begin
      m_known = 1'b1; m_idle = 1'b1; m_out = 1'b0; m_sq = 1'b0;
      m_valid = 1'b0; m_instr = Nop; m_pc = '0; m_next = RstPc;
    end else if (m_known && m_idle) begin
      m_idle = 1'b0;
      if (rd) m_next = tgt_al;
    end else if (m_known) begin
      g_eff  = exp_req && g_drv;
      rv_eff = rv_drv && m_out;
      if (rd) begin
        m_next = tgt_al;
        if (m_valid) begin
          m_valid = 1'b0;
          m_instr = Nop;
        end
        if (rv_eff) begin
          m_out = 1'b0;
          m_sq  = 1'b0;
        end else if (m_out) begin
          m_sq = 1'b1;
        end
        if (g_eff) begin
          m_out = 1'b1;
          m_sq  = 1'b1;
        end
      end else begin
        if (m_valid && rdy) begin
          m_valid = 1'b0;
          m_instr = Nop;
        end
        if (g_eff) begin
          m_out = 1'b1;
          m_sq  = 1'b0;
        end
        if (rv_eff) begin
          m_out = 1'b0;
          if (!m_sq) begin
            m_valid = 1'b1;
            m_instr = rdata_drv;
            m_pc    = m_next;
            m_next  = m_next + 32'd4;
          end
          m_sq = 1'b0;
        end
      end
    end
    #1;
    cyc++;
  endtask

  task automatic fresh_reset();
    mem_pend = 1'b0;
    step(1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic wait_valid(input logic [31:0] pc, input bit rdy, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (instr_valid && instr_pc == pc) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, 1'b0, '0, rdy);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  initial begin
    bit          ok;
    logic [31:0] held;
    bit          r, rd, rdy;
    logic [31:0] tgt;

    // Reset state and steady streaming
    fresh_reset();
    check_eq("rst_valid", 32'(instr_valid), 32'h0);
    check_eq("rst_instr", instr, Nop);
    check_eq("rst_pc", instr_pc, 32'h0);
    check_eq("rst_req", 32'(imem_req), 32'h0);
    vq_pc.delete(); vq_cyc.delete(); rq_addr.delete();
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, '0, 1'b1);
    if (vq_pc.size() < 3 || rq_addr.size() < 3) begin
      check_eq("stream_count", 32'(vq_pc.size()), 32'd3);
    end else begin
      for (int i = 0; i < 3; i++) begin
        check_eq("stream_req_addr", rq_addr[i], 32'(4 * i));
        check_eq("stream_pc", vq_pc[i], 32'(4 * i));
      end
      for (int i = 1; i < 3; i++) check_eq("stream_period", 32'(vq_cyc[i] - vq_cyc[i-1]), 32'd3);
    end

    // Backpressure on the instruction at 0x4
    fresh_reset();
    wait_valid(32'h0, 1'b1, ok);
    check_eq("bp_wait0", 32'(ok), 32'h1);
    step(1'b0, 1'b0, '0, 1'b1);
    wait_valid(32'h4, 1'b0, ok);
    check_eq("bp_wait4", 32'(ok), 32'h1);
    held = instr;
    check_eq("bp_data", held, mem_fn(32'h4));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      check_eq("bp_instr", instr, held);
      check_eq("bp_pc", instr_pc, 32'h4);
      check_eq("bp_noreq", 32'(imem_req), 32'h0);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    check_eq("bp_next_req", 32'(imem_req), 32'h1);
    check_eq("bp_next_addr", imem_addr, 32'h8);

    // Redirect while waiting: squashed data never reaches decode
    lat_min = 3; lat_max = 3; ovr_en = 1'b1;
    fresh_reset();
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    ovr_en = 1'b0; seen_bad = 1'b0;
    wait_req(ok);
    check_eq("rw_req", 32'(ok), 32'h1);
    check_eq("rw_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1);
    check_eq("rw_no_stale", 32'(seen_bad), 32'h0);

    // Redirect coincident with rvalid
    lat_min = 1; lat_max = 1;
    fresh_reset();
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    check_eq("rc_valid", 32'(instr_valid), 32'h0);
    check_eq("rc_req", 32'(imem_req), 32'h1);
    check_eq("rc_addr", imem_addr, 32'h0000_0200);

    // Redirect while holding with no ready
    fresh_reset();
    wait_valid(32'h0, 1'b0, ok);
    check_eq("rh_wait", 32'(ok), 32'h1);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    check_eq("rh_valid", 32'(instr_valid), 32'h0);
    check_eq("rh_instr", instr, Nop);
    check_eq("rh_addr", imem_addr, 32'h0000_0040);

    // PC wrap
    fresh_reset();
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    wait_valid(32'hFFFF_FFFC, 1'b1, ok);
    check_eq("wrap_wait", 32'(ok), 32'h1);
    step(1'b0, 1'b0, '0, 1'b1);
    check_eq("wrap_req", 32'(imem_req), 32'h1);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reset mid-fetch; the stale response lands while requesting and is ignored
    lat_min = 3; lat_max = 3; ovr_en = 1'b1;
    fresh_reset();
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    ovr_en = 1'b0;
    step(1'b0, 1'b0, '0, 1'b1);
    check_eq("rm_req", 32'(imem_req), 32'h1);
    check_eq("rm_addr", imem_addr, RstPc);
    wait_valid(RstPc, 1'b1, ok);
    check_eq("rm_wait", 32'(ok), 32'h1);
    check_eq("rm_instr", instr, mem_fn(RstPc));

    // Randomized traffic
    gnt_pct = 60; spur_pct = 10; lat_min = 1; lat_max = 4;
    fresh_reset();
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(199, 0) == 0);
      rd  = ($urandom_range(99, 0) < 8);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                        : $urandom;
      rdy = ($urandom_range(99, 0) < 70);
      step(r, rd, tgt, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
